// File: rtl/ctrl_pkg.sv
// Shared types for the control pipeline: the 10-bit decoder control bundle (decoder bit order) and its codes.
package ctrl_pkg;

  typedef struct packed {
    logic [1:0] jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = 10'b0;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b11;

  localparam logic [1:0] ALUOP_LS     = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // JAL is the only encoding whose rs1 field is not a real operand.
  function automatic logic uses_rs1(input logic [1:0] jump);
    return jump != JMP_JAL;
  endfunction

  function automatic logic uses_rs2(input logic alu_src, input logic mem_write, input logic branch);
    return !alu_src || mem_write || branch;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-to-datapath control bus for ctrl_pipe; perf counters present only with CTRL_PIPE_PERF_EN.
interface ctrl_pipe_if #(
  parameter int REG_ADDR_W = 5
`ifdef CTRL_PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
);
  logic                  id_valid;
  logic [1:0]            id_jump;
  logic                  id_branch;
  logic                  id_mem_read;
  logic                  id_mem_to_reg;
  logic [1:0]            id_alu_op;
  logic                  id_mem_write;
  logic                  id_alu_src;
  logic                  id_reg_write;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  flush_i;
  logic                  stall_o;
  logic                  ex_valid;
  logic [1:0]            ex_jump;
  logic                  ex_branch;
  logic [1:0]            ex_alu_op;
  logic                  ex_alu_src;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid;
  logic                  wb_mem_to_reg;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
`endif

  modport master (
`ifdef CTRL_PIPE_PERF_EN
    input  stall_cnt, flush_cnt,
`endif
    output id_valid, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_alu_op,
           id_mem_write, id_alu_src, id_reg_write, id_rs1, id_rs2, id_rd, flush_i,
    input  stall_o, ex_valid, ex_jump, ex_branch, ex_alu_op, ex_alu_src, ex_rd,
           mem_valid, mem_mem_read, mem_mem_write, mem_rd,
           wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd
  );

  modport slave (
`ifdef CTRL_PIPE_PERF_EN
    output stall_cnt, flush_cnt,
`endif
    input  id_valid, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_alu_op,
           id_mem_write, id_alu_src, id_reg_write, id_rs1, id_rs2, id_rd, flush_i,
    output stall_o, ex_valid, ex_jump, ex_branch, ex_alu_op, ex_alu_src, ex_rd,
           mem_valid, mem_mem_read, mem_mem_write, mem_rd,
           wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd
  );
endinterface

// File: rtl/ctrl_load_use_detect.sv
// Combinational load-use hazard check between the instruction in ID and a load sitting in EX.
module ctrl_load_use_detect
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_id_valid,
  input  logic [1:0]            i_id_jump,
  input  logic                  i_id_branch,
  input  logic                  i_id_mem_write,
  input  logic                  i_id_alu_src,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_load_use
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = uses_rs1(i_id_jump) && (i_ex_rd == i_id_rs1);
  assign w_rs2_hit = uses_rs2(i_id_alu_src, i_id_mem_write, i_id_branch) && (i_ex_rd == i_id_rs2);

  // A load to x0 produces nothing to wait for.
  assign o_load_use = i_id_valid && i_ex_valid && i_ex_mem_read && (i_ex_rd != '0)
                      && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall and flush bubbles.
// Define CTRL_PIPE_PERF_EN to add stall/flush cycle counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef CTRL_PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic      clk,
  input  logic      reset_n,
  ctrl_pipe_if.slave bus
);
  ctrl_bundle_t          w_id_ctrl;
  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_id_kill;

  logic                  r_ex_valid;
  ctrl_bundle_t          r_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_mem_valid;
  logic                  r_mem_mem_read;
  logic                  r_mem_mem_write;
  logic                  r_mem_mem_to_reg;
  logic                  r_mem_reg_write;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_wb_valid;
  logic                  r_wb_mem_to_reg;
  logic                  r_wb_reg_write;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  // x0 is never a write target, so reg_write is dropped at capture time.
  assign w_id_ctrl = '{jump:       bus.id_jump,
                       branch:     bus.id_branch,
                       mem_read:   bus.id_mem_read,
                       mem_to_reg: bus.id_mem_to_reg,
                       alu_op:     bus.id_alu_op,
                       mem_write:  bus.id_mem_write,
                       alu_src:    bus.id_alu_src,
                       reg_write:  bus.id_reg_write && (bus.id_rd != '0)};

  ctrl_load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .i_id_valid     (bus.id_valid),
    .i_id_jump      (bus.id_jump),
    .i_id_branch    (bus.id_branch),
    .i_id_mem_write (bus.id_mem_write),
    .i_id_alu_src   (bus.id_alu_src),
    .i_id_rs1       (bus.id_rs1),
    .i_id_rs2       (bus.id_rs2),
    .i_ex_valid     (r_ex_valid),
    .i_ex_mem_read  (r_ex_ctrl.mem_read),
    .i_ex_rd        (r_ex_rd),
    .o_load_use     (w_load_use)
  );

  // A flushed instruction is discarded anyway, so it never needs to stall.
  assign w_stall   = w_load_use && !bus.flush_i;
  assign w_id_kill = bus.flush_i || w_stall || !bus.id_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid       <= 1'b0;
      r_ex_ctrl        <= CTRL_BUBBLE;
      r_ex_rd          <= '0;
      r_mem_valid      <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_rd         <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_reg_write   <= 1'b0;
      r_wb_rd          <= '0;
    end else begin
      if (w_id_kill) begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= CTRL_BUBBLE;
        r_ex_rd    <= '0;
      end else begin
        r_ex_valid <= 1'b1;
        r_ex_ctrl  <= w_id_ctrl;
        r_ex_rd    <= bus.id_rd;
      end
      r_mem_valid      <= r_ex_valid;
      r_mem_mem_read   <= r_ex_ctrl.mem_read;
      r_mem_mem_write  <= r_ex_ctrl.mem_write;
      r_mem_mem_to_reg <= r_ex_ctrl.mem_to_reg;
      r_mem_reg_write  <= r_ex_ctrl.reg_write;
      r_mem_rd         <= r_ex_rd;
      r_wb_valid       <= r_mem_valid;
      r_wb_mem_to_reg  <= r_mem_mem_to_reg;
      r_wb_reg_write   <= r_mem_reg_write;
      r_wb_rd          <= r_mem_rd;
    end
  end

  assign bus.stall_o       = w_stall;
  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_jump       = r_ex_ctrl.jump;
  assign bus.ex_branch     = r_ex_ctrl.branch;
  assign bus.ex_alu_op     = r_ex_ctrl.alu_op;
  assign bus.ex_alu_src    = r_ex_ctrl.alu_src;
  assign bus.ex_rd         = r_ex_rd;
  assign bus.mem_valid     = r_mem_valid;
  assign bus.mem_mem_read  = r_mem_mem_read;
  assign bus.mem_mem_write = r_mem_mem_write;
  assign bus.mem_rd        = r_mem_rd;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_mem_to_reg = r_wb_mem_to_reg;
  assign bus.wb_reg_write  = r_wb_reg_write;
  assign bus.wb_rd         = r_wb_rd;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)     r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush_i) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expected ID/EX contents queued at drive time, shifted through MEM/WB.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int RW = 5;
`ifdef CTRL_PIPE_PERF_EN
  localparam int CW = 4;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

`ifdef CTRL_PIPE_PERF_EN
  ctrl_pipe_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();
  ctrl_pipe #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
  ctrl_pipe_if #(.REG_ADDR_W(RW)) bus ();
  ctrl_pipe #(.REG_ADDR_W(RW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  typedef struct packed {
    logic          valid;
    logic [1:0]    jump;
    logic          branch;
    logic          mem_read;
    logic          mem_to_reg;
    logic [1:0]    alu_op;
    logic          mem_write;
    logic          alu_src;
    logic          reg_write;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
  } instr_t;

  typedef struct packed {
    logic          valid;
    logic [1:0]    jump;
    logic          branch;
    logic [1:0]    alu_op;
    logic          alu_src;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_write;
    logic [RW-1:0] rd;
  } stage_t;

  stage_t exp_q[$];
  stage_t m_ex, m_mem, m_wb;
  int n_checks = 0;
  int n_fail = 0;
`ifdef CTRL_PIPE_PERF_EN
  logic [CW-1:0] m_stall_cnt, m_flush_cnt;
`endif

  function automatic instr_t rtype(input int rd, input int rs1, input int rs2);
    instr_t t = '0;
    t.valid = 1'b1; t.alu_op = ALUOP_RTYPE; t.reg_write = 1'b1;
    t.rd = RW'(rd); t.rs1 = RW'(rs1); t.rs2 = RW'(rs2);
    return t;
  endfunction

  function automatic instr_t itype(input int rd, input int rs1, input int rs2_field);
    instr_t t = '0;
    t.valid = 1'b1; t.alu_op = ALUOP_ITYPE; t.alu_src = 1'b1; t.reg_write = 1'b1;
    t.rd = RW'(rd); t.rs1 = RW'(rs1); t.rs2 = RW'(rs2_field);
    return t;
  endfunction

  function automatic instr_t load(input int rd, input int rs1);
    instr_t t = '0;
    t.valid = 1'b1; t.mem_read = 1'b1; t.mem_to_reg = 1'b1; t.alu_src = 1'b1;
    t.reg_write = 1'b1; t.alu_op = ALUOP_LS; t.rd = RW'(rd); t.rs1 = RW'(rs1);
    return t;
  endfunction

  function automatic instr_t store(input int rs1, input int rs2);
    instr_t t = '0;
    t.valid = 1'b1; t.mem_write = 1'b1; t.alu_src = 1'b1; t.alu_op = ALUOP_LS;
    t.rs1 = RW'(rs1); t.rs2 = RW'(rs2);
    return t;
  endfunction

  function automatic instr_t jal(input int rd, input int rs1_field);
    instr_t t = '0;
    t.valid = 1'b1; t.jump = JMP_JAL; t.reg_write = 1'b1; t.alu_src = 1'b1;
    t.rd = RW'(rd); t.rs1 = RW'(rs1_field); t.rs2 = RW'(rs1_field);
    return t;
  endfunction

  function automatic instr_t beq(input int rs1, input int rs2);
    instr_t t = '0;
    t.valid = 1'b1; t.branch = 1'b1; t.alu_op = ALUOP_BRANCH;
    t.rs1 = RW'(rs1); t.rs2 = RW'(rs2);
    return t;
  endfunction

  // Expected hazard from the instruction definition and the model's view of EX.
  function automatic logic exp_stall(input instr_t t, input logic fl);
    logic u1, u2, lu;
    u1 = (t.jump != 2'b01);
    u2 = !t.alu_src || t.mem_write || t.branch;
    lu = t.valid && m_ex.valid && m_ex.mem_read && (m_ex.rd != '0) &&
         ((u1 && m_ex.rd == t.rs1) || (u2 && m_ex.rd == t.rs2));
    return lu && !fl;
  endfunction

  function automatic stage_t to_stage(input instr_t t);
    stage_t s;
    s.valid = 1'b1; s.jump = t.jump; s.branch = t.branch; s.alu_op = t.alu_op;
    s.alu_src = t.alu_src; s.mem_read = t.mem_read; s.mem_write = t.mem_write;
    s.mem_to_reg = t.mem_to_reg; s.reg_write = t.reg_write && (t.rd != '0); s.rd = t.rd;
    return s;
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({bus.stall_o, bus.ex_valid, bus.ex_jump, bus.ex_branch, bus.ex_alu_op,
                bus.ex_alu_src, bus.ex_rd, bus.mem_valid, bus.mem_mem_read, bus.mem_mem_write,
                bus.mem_rd, bus.wb_valid, bus.wb_mem_to_reg, bus.wb_reg_write, bus.wb_rd});
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_ex = '0; m_mem = '0; m_wb = '0;
`ifdef CTRL_PIPE_PERF_EN
    m_stall_cnt = '0; m_flush_cnt = '0;
`endif
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input instr_t t, input logic fl, output logic stalled);
    logic es;
    stage_t popped;
    bus.id_valid = t.valid; bus.id_jump = t.jump; bus.id_branch = t.branch;
    bus.id_mem_read = t.mem_read; bus.id_mem_to_reg = t.mem_to_reg; bus.id_alu_op = t.alu_op;
    bus.id_mem_write = t.mem_write; bus.id_alu_src = t.alu_src; bus.id_reg_write = t.reg_write;
    bus.id_rs1 = t.rs1; bus.id_rs2 = t.rs2; bus.id_rd = t.rd; bus.flush_i = fl;
    #1;
    es = exp_stall(t, fl);
    n_checks++;
    if (bus.stall_o !== es) begin
      n_fail++;
      $display("FAIL stall_o: got %b expected %b", bus.stall_o, es);
    end
    if (fl || es || !t.valid) exp_q.push_back('0);
    else exp_q.push_back(to_stage(t));
`ifdef CTRL_PIPE_PERF_EN
    if (es) m_stall_cnt++;
    if (fl) m_flush_cnt++;
`endif
    @(posedge clk);
    #1;
    popped = exp_q.pop_front();
    m_wb = m_mem; m_mem = m_ex; m_ex = popped;
    n_checks += 3;
    if ({bus.ex_valid, bus.ex_jump, bus.ex_branch, bus.ex_alu_op, bus.ex_alu_src, bus.ex_rd} !==
        {m_ex.valid, m_ex.jump, m_ex.branch, m_ex.alu_op, m_ex.alu_src, m_ex.rd}) begin
      n_fail++;
      $display("FAIL ex_stage: got v=%b j=%b br=%b op=%b src=%b rd=%0d expected v=%b j=%b br=%b op=%b src=%b rd=%0d",
               bus.ex_valid, bus.ex_jump, bus.ex_branch, bus.ex_alu_op, bus.ex_alu_src, bus.ex_rd,
               m_ex.valid, m_ex.jump, m_ex.branch, m_ex.alu_op, m_ex.alu_src, m_ex.rd);
    end
    if ({bus.mem_valid, bus.mem_mem_read, bus.mem_mem_write, bus.mem_rd} !==
        {m_mem.valid, m_mem.mem_read, m_mem.mem_write, m_mem.rd}) begin
      n_fail++;
      $display("FAIL mem_stage: got v=%b rd_en=%b wr_en=%b rd=%0d expected v=%b rd_en=%b wr_en=%b rd=%0d",
               bus.mem_valid, bus.mem_mem_read, bus.mem_mem_write, bus.mem_rd,
               m_mem.valid, m_mem.mem_read, m_mem.mem_write, m_mem.rd);
    end
    if ({bus.wb_valid, bus.wb_mem_to_reg, bus.wb_reg_write, bus.wb_rd} !==
        {m_wb.valid, m_wb.mem_to_reg, m_wb.reg_write, m_wb.rd}) begin
      n_fail++;
      $display("FAIL wb_stage: got v=%b m2r=%b we=%b rd=%0d expected v=%b m2r=%b we=%b rd=%0d",
               bus.wb_valid, bus.wb_mem_to_reg, bus.wb_reg_write, bus.wb_rd,
               m_wb.valid, m_wb.mem_to_reg, m_wb.reg_write, m_wb.rd);
    end
    $display("txn t=%0t id_v=%b rd=%0d rs1=%0d rs2=%0d flush=%b stall=%b | ex v=%b rd=%0d | mem v=%b rd=%0d | wb v=%b we=%b rd=%0d",
             $time, t.valid, t.rd, t.rs1, t.rs2, fl, es, bus.ex_valid, bus.ex_rd,
             bus.mem_valid, bus.mem_rd, bus.wb_valid, bus.wb_reg_write, bus.wb_rd);
    stalled = es;
  endtask

  task automatic drain(input int n);
    logic s;
    for (int i = 0; i < n; i++) step('0, 1'b0, s);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (all_outputs() !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
`ifdef CTRL_PIPE_PERF_EN
    n_checks++;
    if ({bus.stall_cnt, bus.flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
    model_clear();
    reset_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic s;
    step(rtype(5, 1, 2), 1'b0, s);
    n_checks++;
    if (bus.ex_alu_op !== 2'b10 || bus.ex_rd !== 5'd5) begin
      n_fail++;
      $display("FAIL rtype_ex: got op=%b rd=%0d expected op=10 rd=5", bus.ex_alu_op, bus.ex_rd);
    end
    drain(2);
    n_checks++;
    if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'd5) begin
      n_fail++;
      $display("FAIL rtype_wb: got we=%b rd=%0d expected we=1 rd=5", bus.wb_reg_write, bus.wb_rd);
    end
    drain(1);
  endtask

  task automatic test_load_use();
    logic s;
    step(load(6, 1), 1'b0, s);
    step(rtype(7, 6, 1), 1'b0, s);
    n_checks++;
    if (s !== 1'b1 || bus.ex_valid !== 1'b0 || bus.mem_mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_stall: got stall=%b ex_v=%b mem_rd_en=%b expected 1 0 1", s, bus.ex_valid, bus.mem_mem_read);
    end
    step(rtype(7, 6, 1), 1'b0, s);
    n_checks++;
    if (s !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd7) begin
      n_fail++;
      $display("FAIL load_use_release: got stall=%b ex_v=%b ex_rd=%0d expected 0 1 7", s, bus.ex_valid, bus.ex_rd);
    end
    drain(3);
  endtask

  task automatic test_no_hazard();
    logic s;
    step(load(6, 1), 1'b0, s);
    step(itype(7, 0, 6), 1'b0, s);
    n_checks++;
    if (s !== 1'b0) begin
      n_fail++;
      $display("FAIL no_use_stall: got %b expected 0", s);
    end
    step(load(0, 1), 1'b0, s);
    step(rtype(7, 0, 0), 1'b0, s);
    n_checks++;
    if (s !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_load_stall: got %b expected 0", s);
    end
    drain(3);
  endtask

  task automatic test_operand_use();
    logic s;
    step(load(6, 1), 1'b0, s);
    step(jal(1, 6), 1'b0, s);
    n_checks++;
    if (s !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_rs1_stall: got %b expected 0", s);
    end
    step(load(9, 1), 1'b0, s);
    step(store(2, 9), 1'b0, s);
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++;
      $display("FAIL store_rs2_stall: got %b expected 1", s);
    end
    step(store(2, 9), 1'b0, s);
    step(load(3, 1), 1'b0, s);
    step(beq(4, 3), 1'b0, s);
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_rs2_stall: got %b expected 1", s);
    end
    step(beq(4, 3), 1'b0, s);
    drain(3);
  endtask

  task automatic test_flush();
    logic s;
    step(load(6, 1), 1'b0, s);
    step(rtype(7, 6, 1), 1'b1, s);
    n_checks++;
    if (s !== 1'b0 || bus.ex_valid !== 1'b0 || bus.mem_mem_read !== 1'b1 || bus.mem_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL flush_wins: got stall=%b ex_v=%b mem_rd_en=%b mem_rd=%0d expected 0 0 1 6",
               s, bus.ex_valid, bus.mem_mem_read, bus.mem_rd);
    end
    drain(3);
  endtask

  task automatic test_x0_and_reset();
    logic s;
    step(itype(0, 0, 0), 1'b0, s);
    drain(2);
    n_checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write: got v=%b we=%b expected v=1 we=0", bus.wb_valid, bus.wb_reg_write);
    end
    step(rtype(5, 1, 2), 1'b0, s);
    step(load(6, 1), 1'b0, s);
    step(rtype(8, 2, 3), 1'b0, s);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_outputs() !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", all_outputs());
    end
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic s;
    instr_t t;
    logic fl;
    int kind;
    t = '0;
    s = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!s) begin
        kind = int'($urandom_range(0, 5));
        case (kind)
          0: t = load(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          1: t = rtype(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          2: t = itype(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          3: t = store(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          4: t = beq(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          default: t = '0;
        endcase
      end
      fl = ($urandom_range(0, 7) == 0);
      step(t, fl, s);
    end
    drain(3);
  endtask

`ifdef CTRL_PIPE_PERF_EN
  task automatic test_perf();
    logic s;
    reset_n = 1'b0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(load(6, 1), 1'b0, s);
      step(rtype(7, 6, 1), 1'b0, s);
      step(rtype(7, 6, 1), 1'b0, s);
    end
    step(rtype(2, 1, 1), 1'b1, s);
    step(rtype(2, 1, 1), 1'b1, s);
    n_checks++;
    if (bus.stall_cnt !== 4'd3 || bus.flush_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL perf_counts: got %0d/%0d expected 3/2", bus.stall_cnt, bus.flush_cnt);
    end
    for (int i = 0; i < 13; i++) begin
      step(load(6, 1), 1'b0, s);
      step(rtype(7, 6, 1), 1'b0, s);
      step(rtype(7, 6, 1), 1'b0, s);
    end
    n_checks++;
    if (bus.stall_cnt !== 4'd0 || bus.stall_cnt !== m_stall_cnt || bus.flush_cnt !== m_flush_cnt) begin
      n_fail++;
      $display("FAIL perf_wrap: got %0d/%0d expected 0/%0d", bus.stall_cnt, bus.flush_cnt, m_flush_cnt);
    end
  endtask
`endif

  initial begin
    bus.id_valid = 1'b0; bus.id_jump = '0; bus.id_branch = 1'b0; bus.id_mem_read = 1'b0;
    bus.id_mem_to_reg = 1'b0; bus.id_alu_op = '0; bus.id_mem_write = 1'b0; bus.id_alu_src = 1'b0;
    bus.id_reg_write = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.flush_i = 1'b0;
    model_clear();
    test_reset();
    test_rtype();
    test_load_use();
    test_no_hazard();
    test_operand_use();
    test_flush();
    test_x0_and_reset();
    test_back_to_back();
`ifdef CTRL_PIPE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
